// File: rtl/isolde_xif_pkg.sv
// Shared types for the CV-X-IF offload controller: scoreboard entry and controller FSM states.
package isolde_xif_pkg;

    localparam int unsigned X_INSTR_W = 32;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCommit
    } state_e;

endpackage

// File: rtl/isolde_xif_offload_ctrl_lzc.sv
// Trailing-zero counter with a common_cells lzc-compatible interface; applied to the free-entry
// vector it yields the lowest free index.
module isolde_xif_offload_ctrl_lzc #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CntWidth = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]    in_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                empty_o
);

    always_comb begin
        cnt_o = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CntWidth'(i);
            end
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/isolde_xif_offload_ctrl.sv
// Core-side CV-X-IF initiator: issues offloaded instructions, commits them, tracks write-back IDs
// in a small scoreboard and retires out-of-order results into the host register file.
module isolde_xif_offload_ctrl
    import isolde_xif_pkg::*;
#(
    parameter int unsigned NumEntries = 4,
    parameter int unsigned XLEN       = 32,
    localparam int unsigned IdWidth   = $clog2(NumEntries)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 off_valid_i,
    output logic                 off_ready_o,
    input  logic [X_INSTR_W-1:0] off_instr_i,
    input  logic [2*XLEN-1:0]    off_rs_i,
    input  logic [1:0]           off_rs_valid_i,
    input  logic [4:0]           off_rd_i,
    input  logic                 kill_i,
    output logic                 off_resp_valid_o,
    output logic                 off_resp_accept_o,
    output logic                 issue_valid_o,
    input  logic                 issue_ready_i,
    output logic [X_INSTR_W-1:0] issue_instr_o,
    output logic [2*XLEN-1:0]    issue_rs_o,
    output logic [1:0]           issue_rs_valid_o,
    output logic [IdWidth-1:0]   issue_id_o,
    input  logic                 issue_accept_i,
    input  logic                 issue_writeback_i,
    output logic                 commit_valid_o,
    output logic [IdWidth-1:0]   commit_id_o,
    output logic                 commit_kill_o,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    input  logic [IdWidth-1:0]   result_id_i,
    input  logic [XLEN-1:0]      result_data_i,
    input  logic                 result_we_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    input  logic                 rf_gnt_i,
    output logic                 busy_o,
    output logic                 err_o
);

    state_e                         state_q, state_d;
    sb_entry_t [NumEntries-1:0]     sb_q, sb_d;
    logic      [X_INSTR_W-1:0]      instr_q, instr_d;
    logic      [2*XLEN-1:0]         rs_q, rs_d;
    logic      [1:0]                rs_valid_q, rs_valid_d;
    logic      [4:0]                rd_q, rd_d;
    logic      [IdWidth-1:0]        id_q, id_d;
    logic                           err_q, err_d;
    // Holds off_ready_o low while in reset and for the first cycle after it.
    logic                           out_en_q;

    logic      [NumEntries-1:0]     free_vec;
    logic      [IdWidth-1:0]        free_id;
    logic                           no_free;
    logic                           result_hs;
    logic                           result_hit;

    always_comb begin
        for (int i = 0; i < NumEntries; i++) begin
            free_vec[i] = ~sb_q[i].valid;
        end
    end

    isolde_xif_offload_ctrl_lzc #(
        .WIDTH    (NumEntries),
        .CntWidth (IdWidth)
    ) u_free_lzc (
        .in_i    (free_vec),
        .cnt_o   (free_id),
        .empty_o (no_free)
    );

    assign result_hs      = result_valid_i && rf_gnt_i;
    assign result_hit     = sb_q[result_id_i].valid;
    assign result_ready_o = rf_gnt_i;
    assign rf_we_o        = result_hs && result_hit && result_we_i;
    assign rf_waddr_o     = rf_we_o ? sb_q[result_id_i].rd : 5'd0;
    assign rf_wdata_o     = rf_we_o ? result_data_i : '0;

    assign busy_o = (~&free_vec) || (state_q != StIdle);
    assign err_o  = err_q;

    assign issue_instr_o    = issue_valid_o ? instr_q : '0;
    assign issue_rs_o       = issue_valid_o ? rs_q : '0;
    assign issue_rs_valid_o = issue_valid_o ? rs_valid_q : 2'b00;
    assign issue_id_o       = issue_valid_o ? id_q : '0;

    always_comb begin
        state_d           = state_q;
        sb_d              = sb_q;
        instr_d           = instr_q;
        rs_d              = rs_q;
        rs_valid_d        = rs_valid_q;
        rd_d              = rd_q;
        id_d              = id_q;
        err_d             = err_q;
        off_ready_o       = 1'b0;
        off_resp_valid_o  = 1'b0;
        off_resp_accept_o = 1'b0;
        issue_valid_o     = 1'b0;
        commit_valid_o    = 1'b0;
        commit_id_o       = '0;
        commit_kill_o     = 1'b0;

        // Retirement is applied first; an allocation in the same cycle targets a different index.
        if (result_hs) begin
            if (result_hit) begin
                sb_d[result_id_i].valid = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                off_ready_o = out_en_q && !no_free;
                if (off_valid_i && off_ready_o) begin
                    instr_d    = off_instr_i;
                    rs_d       = off_rs_i;
                    rs_valid_d = off_rs_valid_i;
                    rd_d       = off_rd_i;
                    id_d       = free_id;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                issue_valid_o = 1'b1;
                if (issue_ready_i) begin
                    if (issue_accept_i) begin
                        if (issue_writeback_i) begin
                            sb_d[id_q].valid = 1'b1;
                            sb_d[id_q].rd    = rd_q;
                        end
                        state_d = StCommit;
                    end else begin
                        off_resp_valid_o = 1'b1;
                        state_d          = StIdle;
                    end
                end
            end
            StCommit: begin
                commit_valid_o    = 1'b1;
                commit_id_o       = id_q;
                commit_kill_o     = kill_i;
                off_resp_valid_o  = 1'b1;
                off_resp_accept_o = 1'b1;
                if (kill_i) begin
                    sb_d[id_q].valid = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            sb_q       <= '0;
            instr_q    <= '0;
            rs_q       <= '0;
            rs_valid_q <= 2'b00;
            rd_q       <= 5'd0;
            id_q       <= '0;
            err_q      <= 1'b0;
            out_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_q       <= sb_d;
            instr_q    <= instr_d;
            rs_q       <= rs_d;
            rs_valid_q <= rs_valid_d;
            rd_q       <= rd_d;
            id_q       <= id_d;
            err_q      <= err_d;
            out_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_isolde_xif_offload_ctrl.sv
// Scoreboard bench for isolde_xif_offload_ctrl: directed offloads push expectations, a monitor
// pops and compares on every issue handshake, commit, offload response and RF write.
module tb_isolde_xif_offload_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        off_valid = 1'b0;
    logic        off_ready;
    logic [31:0] off_instr = '0;
    logic [63:0] off_rs = '0;
    logic [1:0]  off_rs_valid = '0;
    logic [4:0]  off_rd = '0;
    logic        kill = 1'b0;
    logic        off_resp_valid, off_resp_accept;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_instr;
    logic [63:0] issue_rs;
    logic [1:0]  issue_rs_valid;
    logic [1:0]  issue_id;
    logic        issue_accept = 1'b0;
    logic        issue_writeback = 1'b0;
    logic        commit_valid;
    logic [1:0]  commit_id;
    logic        commit_kill;
    logic        result_valid = 1'b0;
    logic        result_ready;
    logic [1:0]  result_id = '0;
    logic [31:0] result_data = '0;
    logic        result_we = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_gnt = 1'b1;
    logic        busy, err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] rs;
        logic [1:0]  rsv;
        logic [1:0]  id;
    } iss_t;
    typedef struct {
        logic [1:0] id;
        logic       kill;
    } cmt_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } rfw_t;

    iss_t exp_iss[$];
    cmt_t exp_cmt[$];
    logic exp_resp[$];
    rfw_t exp_rfw[$];

    isolde_xif_offload_ctrl #(
        .NumEntries (4),
        .XLEN       (32)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .off_valid_i       (off_valid),
        .off_ready_o       (off_ready),
        .off_instr_i       (off_instr),
        .off_rs_i          (off_rs),
        .off_rs_valid_i    (off_rs_valid),
        .off_rd_i          (off_rd),
        .kill_i            (kill),
        .off_resp_valid_o  (off_resp_valid),
        .off_resp_accept_o (off_resp_accept),
        .issue_valid_o     (issue_valid),
        .issue_ready_i     (issue_ready),
        .issue_instr_o     (issue_instr),
        .issue_rs_o        (issue_rs),
        .issue_rs_valid_o  (issue_rs_valid),
        .issue_id_o        (issue_id),
        .issue_accept_i    (issue_accept),
        .issue_writeback_i (issue_writeback),
        .commit_valid_o    (commit_valid),
        .commit_id_o       (commit_id),
        .commit_kill_o     (commit_kill),
        .result_valid_i    (result_valid),
        .result_ready_o    (result_ready),
        .result_id_i       (result_id),
        .result_data_i     (result_data),
        .result_we_i       (result_we),
        .rf_we_o           (rf_we),
        .rf_waddr_o        (rf_waddr),
        .rf_wdata_o        (rf_wdata),
        .rf_gnt_i          (rf_gnt),
        .busy_o            (busy),
        .err_o             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: DUT event with no expectation queued at %0t", name, $time);
    endtask

    // Monitor: compares every observable DUT event against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (issue_valid && issue_ready) begin
                if (exp_iss.size() == 0) unexpected("issue");
                else begin
                    iss_t e;
                    e = exp_iss.pop_front();
                    chk("issue_instr", issue_instr, e.instr);
                    chk("issue_rs", issue_rs, e.rs);
                    chk("issue_rs_valid", issue_rs_valid, e.rsv);
                    chk("issue_id", issue_id, e.id);
                end
            end
            if (commit_valid) begin
                if (exp_cmt.size() == 0) unexpected("commit");
                else begin
                    cmt_t c;
                    c = exp_cmt.pop_front();
                    chk("commit_id", commit_id, c.id);
                    chk("commit_kill", commit_kill, c.kill);
                end
            end
            if (off_resp_valid) begin
                if (exp_resp.size() == 0) unexpected("off_resp");
                else chk("off_resp_accept", off_resp_accept, exp_resp.pop_front());
            end
            if (rf_we) begin
                if (exp_rfw.size() == 0) unexpected("rf_write");
                else begin
                    rfw_t w;
                    w = exp_rfw.pop_front();
                    chk("rf_waddr", rf_waddr, w.rd);
                    chk("rf_wdata", rf_wdata, w.data);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offload one instruction; expectations are pushed before the DUT can produce them.
    task automatic offload(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [4:0] rd, input logic acc, input logic wb, input logic kl,
                           input logic [1:0] exp_id, input int delay);
        int n = 0;
        off_valid    = 1'b1;
        off_instr    = instr;
        off_rs       = {rs2, rs1};
        off_rs_valid = 2'b11;
        off_rd       = rd;
        @(negedge clk);
        while (!off_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!off_ready) begin
            checks++;
            failures++;
            $display("FAIL off_ready_timeout: got 0 expected 1 at %0t", $time);
            off_valid = 1'b0;
            return;
        end
        sync();
        off_valid = 1'b0;
        exp_iss.push_back('{instr: instr, rs: {rs2, rs1}, rsv: 2'b11, id: exp_id});
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("stall_issue_valid", issue_valid, 1'b1);
            chk("stall_issue_instr", issue_instr, instr);
            chk("stall_issue_rs", issue_rs, {rs2, rs1});
            chk("stall_issue_id", issue_id, exp_id);
            sync();
        end
        issue_ready     = 1'b1;
        issue_accept    = acc;
        issue_writeback = wb;
        exp_resp.push_back(acc);
        if (acc) exp_cmt.push_back('{id: exp_id, kill: kl});
        sync();
        issue_ready = 1'b0;
        kill        = kl;
        sync();
        kill = 1'b0;
    endtask

    task automatic result(input logic [1:0] id, input logic [31:0] data, input logic we,
                          input logic exp_write, input logic [4:0] rd);
        result_valid = 1'b1;
        result_id    = id;
        result_data  = data;
        result_we    = we;
        if (exp_write) exp_rfw.push_back('{rd: rd, data: data});
        sync();
        result_valid = 1'b0;
    endtask

    function automatic logic [159:0] all_outs();
        return {off_ready, off_resp_valid, off_resp_accept, issue_valid, issue_instr, issue_rs,
                issue_rs_valid, issue_id, commit_valid, commit_id, commit_kill, rf_we, rf_waddr,
                rf_wdata, busy, err};
    endfunction

    initial begin
        #12;
        chk("reset_outputs", all_outs(), '0);
        chk("reset_result_ready", result_ready, 1'b1);
        rst_n = 1'b1;
        sync();

        // 1: basic accepted write-back offload and out-of-band result
        offload(32'h0000_000B, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0, 2'd0, 0);
        @(negedge clk);
        chk("t1_busy_outstanding", busy, 1'b1);
        sync();
        result(2'd0, 32'h0000_CAFE, 1'b1, 1'b1, 5'd3);
        @(negedge clk);
        chk("t1_busy_after_retire", busy, 1'b0);
        sync();

        // 2: coprocessor rejects; no commit, nothing allocated
        offload(32'h0000_100B, 32'd1, 32'd2, 5'd4, 1'b0, 1'b1, 1'b0, 2'd0, 0);
        @(negedge clk);
        chk("t2_busy_after_reject", busy, 1'b0);
        sync();

        // 3: three outstanding, results out of order
        offload(32'h0000_200B, 32'd10, 32'd20, 5'd10, 1'b1, 1'b1, 1'b0, 2'd0, 0);
        offload(32'h0000_300B, 32'd11, 32'd21, 5'd11, 1'b1, 1'b1, 1'b0, 2'd1, 0);
        offload(32'h0000_400B, 32'd12, 32'd22, 5'd12, 1'b1, 1'b1, 1'b0, 2'd2, 0);
        result(2'd2, 32'hAAAA_0002, 1'b1, 1'b1, 5'd12);
        result(2'd0, 32'hAAAA_0000, 1'b1, 1'b1, 5'd10);
        result(2'd1, 32'hAAAA_0001, 1'b1, 1'b1, 5'd11);

        // 4: fill the scoreboard, then a retirement frees exactly that ID
        offload(32'h0000_500B, 32'd0, 32'd0, 5'd20, 1'b1, 1'b1, 1'b0, 2'd0, 0);
        offload(32'h0000_600B, 32'd1, 32'd1, 5'd21, 1'b1, 1'b1, 1'b0, 2'd1, 0);
        offload(32'h0000_700B, 32'd2, 32'd2, 5'd22, 1'b1, 1'b1, 1'b0, 2'd2, 0);
        offload(32'h0000_800B, 32'd3, 32'd3, 5'd23, 1'b1, 1'b1, 1'b0, 2'd3, 0);
        @(negedge clk);
        chk("t4_full_off_ready", off_ready, 1'b0);
        sync();
        result(2'd2, 32'h2222_2222, 1'b1, 1'b1, 5'd22);
        offload(32'h0000_900B, 32'd4, 32'd4, 5'd24, 1'b1, 1'b1, 1'b0, 2'd2, 0);
        result(2'd0, 32'h0000_0020, 1'b1, 1'b1, 5'd20);
        result(2'd1, 32'h0000_0021, 1'b1, 1'b1, 5'd21);
        result(2'd3, 32'h0000_0023, 1'b1, 1'b1, 5'd23);
        result(2'd2, 32'h0000_0024, 1'b1, 1'b1, 5'd24);

        // 5: kill in commit frees the entry; a late result is an error, not a write
        @(negedge clk);
        chk("t5_err_before", err, 1'b0);
        sync();
        offload(32'h0000_A00B, 32'd9, 32'd9, 5'd5, 1'b1, 1'b1, 1'b1, 2'd0, 0);
        @(negedge clk);
        chk("t5_busy_after_kill", busy, 1'b0);
        sync();
        result(2'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0);
        @(negedge clk);
        chk("t5_err_sticky", err, 1'b1);
        sync();

        // 6: issue stall, RF grant stall, then reset in the middle of ISSUE
        offload(32'h0000_B00B, 32'h55, 32'h66, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 5);
        rf_gnt       = 1'b0;
        result_valid = 1'b1;
        result_id    = 2'd0;
        result_data  = 32'h7777_7777;
        result_we    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_result_ready_stall", result_ready, 1'b0);
            chk("t6_rf_we_stall", rf_we, 1'b0);
            sync();
        end
        rf_gnt = 1'b1;
        exp_rfw.push_back('{rd: 5'd7, data: 32'h7777_7777});
        sync();
        result_valid = 1'b0;

        off_valid    = 1'b1;
        off_instr    = 32'h0000_C00B;
        off_rs       = 64'h1;
        off_rs_valid = 2'b01;
        off_rd       = 5'd8;
        sync();
        off_valid = 1'b0;
        @(negedge clk);
        chk("t6_in_issue", issue_valid, 1'b1);
        rf_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs", all_outs(), '0);
        chk("t6_reset_result_ready", result_ready, 1'b0);
        rf_gnt = 1'b1;
        sync();
        rst_n = 1'b1;
        sync();
        @(negedge clk);
        chk("t6_post_reset_ready", off_ready, 1'b1);
        chk("t6_post_reset_busy", busy, 1'b0);

        chk("queue_issue_drained", exp_iss.size(), 0);
        chk("queue_commit_drained", exp_cmt.size(), 0);
        chk("queue_resp_drained", exp_resp.size(), 0);
        chk("queue_rf_drained", exp_rfw.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
